rv_iommu_reg_arb: RTL and testbench
===================================

RV_IOMMU_REG_ARB -- requirements
Module: rv_iommu_reg_arb

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of register-bus requesters (valid range 2..8).
REQ-002 SHALL have parameter TimeoutCycles, default 256, BUSY cycles before abort (valid range 2..65535).
REQ-003 SHALL have parameter reg_req_t, default logic, regbus request struct (addr, write, wdata, wstrb, valid).
REQ-004 SHALL have parameter reg_rsp_t, default logic, regbus response struct (rdata, error, ready).
REQ-005 SHALL have port clk_i  input  1  rising-edge clock, the only clock.
REQ-006 SHALL have port rst_ni  input  1  asynchronous reset, active low.
REQ-007 SHALL have port req_i  input  reg_req_t[NumReq]  requests from the programming-interface masters.
REQ-008 SHALL have port rsp_o  output  reg_rsp_t[NumReq]  responses to the masters.
REQ-009 SHALL have port regmap_req_o  output  reg_req_t  request to the IOMMU register map.
REQ-010 SHALL have port regmap_resp_i  input  reg_rsp_t  response from the register map.
REQ-011 SHALL have port busy_o  output  1  high while state is BUSY.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-013 SHALL, in IDLE with any req_i[k].valid high, pick a winner round-robin starting at index rr_ptr, latch the winner index in gnt_q, and enter BUSY next cycle.
REQ-014 SHALL, in IDLE, drive regmap_req_o.valid=0 and all rsp_o to zero.
REQ-015 SHALL, in BUSY, drive regmap_req_o as req_i[gnt_q] unchanged.
REQ-016 SHALL, in BUSY with regmap_resp_i.ready=1, drive rsp_o[gnt_q] as regmap_resp_i, return to IDLE, and set rr_ptr=(gnt_q+1) mod NumReq.
REQ-017 SHALL keep rsp_o[k] at all-zero for every k other than gnt_q in every cycle.
REQ-018 SHALL have a minimum access latency of 2 cycles, with the request sampled in IDLE at cycle 0 and the response at cycle 1 when the register map answers combinationally.
REQ-019 SHALL sustain at most one access every 2 cycles, with one IDLE cycle between grants.
REQ-020 SHALL, in BUSY, return to IDLE without a response and without updating rr_ptr if req_i[gnt_q].valid drops before ready.
REQ-021 SHALL, on simultaneous requests from all masters with rr_ptr=0, grant the masters in order 0,1,...,NumReq-1.
REQ-022 SHALL compute rr_ptr wrap-around modulo NumReq for non-power-of-two NumReq.
REQ-023 SHALL ignore regmap_resp_i while in IDLE.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously set state=IDLE, gnt_q=0, rr_ptr=0 and the timeout counter to 0, driving all outputs to zero including busy_o.
REQ-025 SHALL, on reset during BUSY, abandon the access with no response, and SHALL grant the first request after reset release to the lowest valid index.

Configuration
REQ-026 SHALL, with macro RV_IOMMU_REG_ARB_TIMEOUT_EN defined, count BUSY cycles from 0.
REQ-027 SHALL, with RV_IOMMU_REG_ARB_TIMEOUT_EN defined and the count reaching TimeoutCycles-1 without ready, drive rsp_o[gnt_q] with ready=1, error=1, rdata=0 and regmap_req_o.valid=0 for that cycle, then return to IDLE and advance rr_ptr.
REQ-028 SHALL, with RV_IOMMU_REG_ARB_TIMEOUT_EN undefined, contain no counter and wait in BUSY indefinitely.

Structure
REQ-029 SHALL take the FSM state enum and the default timeout constant from shared package rv_iommu_reg_pkg.
REQ-030 SHALL place round-robin selection in combinational sub-module rv_iommu_rr_arb, with inputs req vector and rr_ptr and outputs gnt index and any-valid.

Verification
REQ-031 SHALL cover single master: master 0 writes addr 0x10, wdata 0xDEADBEEF, regmap ready same cycle -> regmap valid in cycle 1, rsp_o[0].ready in cycle 1, IDLE in cycle 2.
REQ-032 SHALL cover contention: masters 0 and 1 hold valid continuously from reset -> grants 0,1,0,1, each response 2 cycles apart.
REQ-033 SHALL cover stall: regmap ready held low 5 cycles -> regmap_req_o stable, busy_o high 6 cycles, rsp_o[other]=0 throughout.
REQ-034 SHALL cover timeout with macro defined, TimeoutCycles=4 and regmap ready never high -> rsp_o[gnt].error=1, ready=1 in the 4th BUSY cycle.
REQ-035 SHALL cover reset during BUSY: rst_ni low mid-access -> all outputs 0 immediately, and post-release requests on 1 and 2 grant 1 first.
REQ-036 SHALL cover withdrawal: granted master drops valid in BUSY -> no response, IDLE next cycle, rr_ptr unchanged.

Source files
------------

// File: rtl/rv_iommu_reg_pkg.sv
// Shared definitions for the IOMMU register-bus arbiter: FSM state
// encoding, default timeout and default regbus request/response layouts.
package rv_iommu_reg_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultTimeoutCycles = 256;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } regbus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } regbus_rsp_t;

endpackage

// File: rtl/rv_iommu_rr_arb.sv
// Combinational round-robin picker: scans the request vector starting at
// rr_ptr_i and returns the first valid index, wrapping modulo NumReq.
module rv_iommu_rr_arb #(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic [IdxW-1:0]   gnt_o,
    output logic              valid_o
);

    logic [IdxW:0] cand;
    logic          found;

    // First valid requester at or after the pointer, with explicit wrap so
    // non-power-of-two NumReq never selects an out-of-range index.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        gnt_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_ptr_i} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumReq)) begin
                cand = cand - (IdxW+1)'(NumReq);
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found = 1'b1;
                gnt_o = cand[IdxW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rv_iommu_reg_arb.sv
// Register-bus arbiter in front of the IOMMU register map. One access is
// in flight at a time (IDLE -> BUSY -> IDLE), masters served round-robin.
// Optional BUSY watchdog: define RV_IOMMU_REG_ARB_TIMEOUT_EN to abort an
// access with an error response after TimeoutCycles BUSY cycles.
module rv_iommu_reg_arb
    import rv_iommu_reg_pkg::*;
#(
    parameter int  NumReq        = 2,
    parameter int  TimeoutCycles = DefaultTimeoutCycles,
    parameter type reg_req_t     = regbus_req_t,
    parameter type reg_rsp_t     = regbus_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t req_i [NumReq],
    output reg_rsp_t rsp_o [NumReq],
    output reg_req_t regmap_req_o,
    input  reg_rsp_t regmap_resp_i,
    output logic     busy_o
);

    localparam int IdxW = $clog2(NumReq);

    if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_param_check
        $error("rv_iommu_reg_arb: parameter out of range");
    end

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   rr_next;
    logic [IdxW-1:0]   arb_gnt;
    logic              arb_any;
    logic [NumReq-1:0] req_valid;

`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_hit;
    assign timeout_hit = (cnt_q == 16'(TimeoutCycles - 1));
`endif

    // Collect the valid bits for the round-robin picker.
    always_comb begin
        req_valid = '0;
        for (int k = 0; k < NumReq; k++) begin
            req_valid[k] = req_i[k].valid;
        end
    end

    rv_iommu_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arb (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .valid_o  (arb_any)
    );

    assign rr_next = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + IdxW'(1);
    assign busy_o  = (state_q == ARB_BUSY);

    // Next-state and output decode; outputs stay zero outside a live grant.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_ptr_d     = rr_ptr_q;
        regmap_req_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            rsp_o[k] = '0;
        end
`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                // Register-map response is deliberately not looked at here.
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                regmap_req_o = req_i[gnt_q];
`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (!req_i[gnt_q].valid) begin
                    // Master withdrew: drop the access silently, keep fairness order.
                    state_d = ARB_IDLE;
                end else if (regmap_resp_i.ready) begin
                    rsp_o[gnt_q] = regmap_resp_i;
                    state_d      = ARB_IDLE;
                    rr_ptr_d     = rr_next;
                end
`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    regmap_req_o.valid  = 1'b0;
                    rsp_o[gnt_q].ready  = 1'b1;
                    rsp_o[gnt_q].error  = 1'b1;
                    state_d             = ARB_IDLE;
                    rr_ptr_d            = rr_next;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, grant, pointer and watchdog registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rv_iommu_reg_arb.sv
// Self-checking bench for rv_iommu_reg_arb with three masters and a
// combinational register-map model. Responses are checked via a scoreboard.
module tb_rv_iommu_reg_arb;
    import rv_iommu_reg_pkg::*;

    localparam int N = 3;
    localparam logic [31:0] RDATA_KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rm_ready = 1'b0;
    regbus_req_t req_i [N];
    regbus_rsp_t rsp_o [N];
    regbus_req_t regmap_req_o;
    regbus_rsp_t regmap_resp_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb [$];

    typedef struct packed {
        logic       rst;
        logic [2:0] v;
        logic       rdy;
        logic       busy;
        logic       mv;
        logic [1:0] g;
        logic       rsp;
    } vec_t;
    vec_t vecs [$];

    always #5 clk = ~clk;

    rv_iommu_reg_arb #(
        .NumReq        (N),
        .TimeoutCycles (4),
        .reg_req_t     (regbus_req_t),
        .reg_rsp_t     (regbus_rsp_t)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .rsp_o         (rsp_o),
        .regmap_req_o  (regmap_req_o),
        .regmap_resp_i (regmap_resp_i),
        .busy_o        (busy_o)
    );

    // Register map: answers with a key-scrambled address whenever ready is set.
    always_comb begin
        regmap_resp_i       = '0;
        regmap_resp_i.rdata = regmap_req_o.addr ^ RDATA_KEY;
        regmap_resp_i.ready = rm_ready;
    end

    function automatic regbus_req_t mk_req(input int k, input logic v);
        regbus_req_t r;
        r.addr  = 32'h10 + 32'(k) * 32'h100;
        r.write = 1'b1;
        r.wdata = 32'hDEAD_BEEF + 32'(k);
        r.wstrb = 4'hF;
        r.valid = v;
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input int k);
        regbus_req_t r;
        r = mk_req(k, 1'b1);
        return r.addr ^ RDATA_KEY;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int k, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.idx   = 2'(k);
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus after the edge, return at the falling edge.
    task automatic step(input logic [2:0] v, input logic rdy);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) req_i[k] = mk_req(k, v[k]);
        rm_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) req_i[k] = mk_req(k, 1'b0);
        rm_ready = 1'b0;
        rst_ni   = 1'b0;
        #1;
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_regmap", 128'(regmap_req_o), 128'(0));
        for (int k = 0; k < N; k++) check($sformatf("rst_rsp%0d", k), 128'(rsp_o[k]), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic check_bus(input string name, input logic mv, input int g);
        if (mv) check({name, "_req"}, 128'(regmap_req_o), 128'(mk_req(g, 1'b1)));
        else    check({name, "_valid"}, 128'(regmap_req_o.valid), 128'(0));
    endtask

    // Scoreboard consumer: every ready response must match the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rsp_o[k].ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: master %0d responded, none expected", k);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_idx", 128'(k), 128'(e.idx));
                    check("rsp_rdata", 128'(rsp_o[k].rdata), 128'(e.rdata));
                    check("rsp_error", 128'(rsp_o[k].error), 128'(e.err));
                end
            end else if (rsp_o[k] != '0) begin
                total++;
                bad++;
                $display("FAIL rsp_idle_nonzero: master %0d got %0h want 0", k, rsp_o[k]);
            end
        end
    end

    initial begin
        int busy_cnt;
        for (int k = 0; k < N; k++) req_i[k] = mk_req(k, 1'b0);

        // rst v rdy busy mv g rsp
        // single master write, ready ignored while idle
        vecs.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        // masters 0 and 1 contend: 0,1,0,1
        vecs.push_back('{1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1});
        // all three: 0,1,2 then wrap to 0
        vecs.push_back('{1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].rsp) expect_rsp(int'(vecs[i].g), exp_rdata(int'(vecs[i].g)), 1'b0);
            step(vecs[i].v, vecs[i].rdy);
            check($sformatf("v%0d_busy", i), 128'(busy_o), 128'(vecs[i].busy));
            check_bus($sformatf("v%0d", i), vecs[i].mv, int'(vecs[i].g));
        end

`ifdef RV_IOMMU_REG_ARB_TIMEOUT_EN
        // Watchdog: map never ready, abort with error in the 4th BUSY cycle.
        do_reset();
        step(3'b001, 1'b0);
        check("to_idle_busy", 128'(busy_o), 128'(0));
        for (int c = 1; c <= 3; c++) begin
            step(3'b001, 1'b0);
            check($sformatf("to_c%0d_busy", c), 128'(busy_o), 128'(1));
            check_bus($sformatf("to_c%0d", c), 1'b1, 0);
        end
        expect_rsp(0, 32'h0, 1'b1);
        step(3'b001, 1'b0);
        check("to_c4_busy", 128'(busy_o), 128'(1));
        check_bus("to_c4", 1'b0, 0);
        step(3'b011, 1'b0);
        check("to_after_busy", 128'(busy_o), 128'(0));
        expect_rsp(1, exp_rdata(1), 1'b0);
        step(3'b011, 1'b1);
        check_bus("to_next_grant", 1'b1, 1);
        step(3'b000, 1'b0);
`else
        // Stall: ready low for 5 BUSY cycles, request held steady.
        do_reset();
        busy_cnt = 0;
        step(3'b011, 1'b0);
        check("st_idle_busy", 128'(busy_o), 128'(0));
        for (int c = 0; c < 5; c++) begin
            step(3'b011, 1'b0);
            if (busy_o) busy_cnt++;
            check_bus($sformatf("st_c%0d", c), 1'b1, 0);
            check($sformatf("st_c%0d_rsp1", c), 128'(rsp_o[1]), 128'(0));
        end
        expect_rsp(0, exp_rdata(0), 1'b0);
        step(3'b011, 1'b1);
        if (busy_o) busy_cnt++;
        check("st_last_rsp1", 128'(rsp_o[1]), 128'(0));
        check("st_busy_cycles", 128'(busy_cnt), 128'(6));
        step(3'b000, 1'b0);
        check("st_end_busy", 128'(busy_o), 128'(0));
`endif

        // Reset during BUSY with rr_ptr moved to 2; after reset, 1 wins over 2.
        do_reset();
        step(3'b010, 1'b1);
        expect_rsp(1, exp_rdata(1), 1'b0);
        step(3'b010, 1'b1);
        check("rb_first_busy", 128'(busy_o), 128'(1));
        step(3'b100, 1'b0);
        step(3'b100, 1'b0);
        check_bus("rb_stall", 1'b1, 2);
        #2 rst_ni = 1'b0;
        #1;
        check("rb_async_busy", 128'(busy_o), 128'(0));
        check("rb_async_regmap", 128'(regmap_req_o), 128'(0));
        check("rb_async_rsp2", 128'(rsp_o[2]), 128'(0));
        for (int k = 0; k < N; k++) req_i[k] = mk_req(k, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        step(3'b110, 1'b1);
        check("rb_post_idle", 128'(busy_o), 128'(0));
        expect_rsp(1, exp_rdata(1), 1'b0);
        step(3'b110, 1'b1);
        check_bus("rb_post_grant", 1'b1, 1);
        step(3'b000, 1'b0);

        // Withdrawal: granted master 0 drops valid; pointer must stay at 0.
        do_reset();
        step(3'b011, 1'b0);
        step(3'b011, 1'b0);
        check_bus("wd_grant", 1'b1, 0);
        step(3'b010, 1'b0);
        check("wd_drop_busy", 128'(busy_o), 128'(1));
        check_bus("wd_drop", 1'b0, 0);
        step(3'b011, 1'b1);
        check("wd_idle_busy", 128'(busy_o), 128'(0));
        expect_rsp(0, exp_rdata(0), 1'b0);
        step(3'b011, 1'b1);
        check_bus("wd_regrant", 1'b1, 0);
        step(3'b000, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
